// File: rtl/ascon_pack.sv
// -----------------------------------------------------------------------------
// ascon_pack
// Shared definitions for the ASCON substitution layer.
//   type_state     : 320-bit permutation state, five 64-bit words x0..x4
//   SBOX_TABLE     : forward 5-bit ASCON S-box, indexed by {x0,x1,x2,x3,x4}
//   SBOX_INV_TABLE : inverse S-box, present only when ASCON_PS_INV_EN is defined
// Configuration macro: ASCON_PS_INV_EN
// -----------------------------------------------------------------------------
package ascon_pack;

   localparam int unsigned NUM_WORDS = 5;
   localparam int unsigned WORD_W    = 64;

   typedef logic [63:0] type_state [0:4];

   localparam logic [4:0] SBOX_TABLE [0:31] = '{
      5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
      5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
      5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
      5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17
   };

`ifdef ASCON_PS_INV_EN
   // SBOX_INV_TABLE[SBOX_TABLE[i]] == i for every i
   localparam logic [4:0] SBOX_INV_TABLE [0:31] = '{
      5'h14, 5'h1A, 5'h07, 5'h0D, 5'h00, 5'h09, 5'h0E, 5'h12,
      5'h0A, 5'h06, 5'h1D, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1E,
      5'h18, 5'h16, 5'h0B, 5'h11, 5'h03, 5'h05, 5'h1C, 5'h1F,
      5'h17, 5'h1B, 5'h04, 5'h08, 5'h0F, 5'h0C, 5'h10, 5'h02
   };
`endif

endpackage

// File: rtl/ascon_sbox5.sv
// -----------------------------------------------------------------------------
// ascon_sbox5
// Combinational 5-in/5-out ASCON S-box for a single bit-column.
//   col_in  : column index {x0[j],x1[j],x2[j],x3[j],x4[j]}, x0 is the MSB
//   inv     : 1 selects the inverse S-box (port exists only with ASCON_PS_INV_EN)
//   col_out : substituted column, bit 4 goes to x0, bit 0 to x4
// Configuration macro: ASCON_PS_INV_EN
// -----------------------------------------------------------------------------
module ascon_sbox5
   import ascon_pack::*;
(
   input  logic [4:0] col_in,
`ifdef ASCON_PS_INV_EN
   input  logic       inv,
`endif
   output logic [4:0] col_out
);

   // Table lookup of one column (forward, or inverse when built and selected)
   always_comb begin
      col_out = 5'h00;
`ifdef ASCON_PS_INV_EN
      if (inv) begin
         col_out = SBOX_INV_TABLE[col_in];
      end else begin
         col_out = SBOX_TABLE[col_in];
      end
`else
      col_out = SBOX_TABLE[col_in];
`endif
   end

endmodule

// File: rtl/ascon_sbox_layer.sv
// -----------------------------------------------------------------------------
// ascon_sbox_layer
// Registered ASCON substitution layer p_S: the 5-bit S-box is applied to each
// of the 64 bit-columns of the 320-bit state, result available one cycle later.
//   clock_i  : system clock, rising edge
//   reset_i  : asynchronous active-high reset, clears output and valid
//   valid_i  : Ps_in_i carries a state to substitute this cycle
//   Ps_in_i  : input state x0..x4
//   inv_i    : 1 = inverse S-box (port exists only with ASCON_PS_INV_EN)
//   Ps_out_o : substituted state, held while valid_i is low
//   valid_o  : Ps_out_o holds a fresh result
// Configuration macro: ASCON_PS_INV_EN
// -----------------------------------------------------------------------------
module ascon_sbox_layer
   import ascon_pack::*;
(
   input  logic      clock_i,
   input  logic      reset_i,
   input  logic      valid_i,
   input  type_state Ps_in_i,
`ifdef ASCON_PS_INV_EN
   input  logic      inv_i,
`endif
   output type_state Ps_out_o,
   output logic      valid_o
);

   logic [4:0][63:0] sub_s;
   logic [4:0][63:0] ps_out_r;
   logic             valid_r;

   // One S-box per column; columns are fully independent
   genvar j;
   generate
      for (j = 0; j < WORD_W; j++) begin : g_col
         logic [4:0] col_in_s;
         logic [4:0] col_out_s;

         assign col_in_s = {Ps_in_i[0][j], Ps_in_i[1][j], Ps_in_i[2][j],
                            Ps_in_i[3][j], Ps_in_i[4][j]};

         ascon_sbox5 u_sbox (
            .col_in  (col_in_s),
`ifdef ASCON_PS_INV_EN
            .inv     (inv_i),
`endif
            .col_out (col_out_s)
         );

         assign sub_s[0][j] = col_out_s[4];
         assign sub_s[1][j] = col_out_s[3];
         assign sub_s[2][j] = col_out_s[2];
         assign sub_s[3][j] = col_out_s[1];
         assign sub_s[4][j] = col_out_s[0];
      end
   endgenerate

   // Output state and valid registers; state holds when no new input arrives
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         ps_out_r <= {NUM_WORDS{64'h0}};
         valid_r  <= 1'b0;
      end else begin
         if (valid_i) begin
            ps_out_r <= sub_s;
         end else begin
            ps_out_r <= ps_out_r;
         end
         valid_r <= valid_i;
      end
   end

   // Present the packed register as the unpacked state type
   always_comb begin
      for (int w = 0; w < NUM_WORDS; w++) begin
         Ps_out_o[w] = ps_out_r[w];
      end
   end

   assign valid_o = valid_r;

endmodule

// File: tb/tb_ascon_sbox_layer.sv
`timescale 1ns/1ps
module tb_ascon_sbox_layer;
   import ascon_pack::*;

   typedef logic [4:0][63:0] st_t;

   logic      clk = 1'b0;
   logic      rst;
   logic      valid_in = 1'b0;
   type_state ps_in;
   type_state ps_out;
   logic      valid_out;
`ifdef ASCON_PS_INV_EN
   logic      inv = 1'b0;
`endif

   st_t drv = '0;
   st_t out_p;
   st_t exp_out;
   logic exp_valid;
   bit   cmp_en = 1'b0;

   int checks = 0;
   int errors = 0;

   logic [4:0] spec_s [0:31] = '{
      5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
      5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
      5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
      5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17
   };
   logic [4:0] inv_tab [0:31];

   always #5 clk = ~clk;

   ascon_sbox_layer dut (
      .clock_i  (clk),
      .reset_i  (rst),
      .valid_i  (valid_in),
      .Ps_in_i  (ps_in),
`ifdef ASCON_PS_INV_EN
      .inv_i    (inv),
`endif
      .Ps_out_o (ps_out),
      .valid_o  (valid_out)
   );

   always_comb begin
      for (int w = 0; w < 5; w++) begin
         ps_in[w] = drv[w];
         out_p[w] = ps_out[w];
      end
   end

   // Bitsliced ASCON S-box (reference-implementation formulation)
   function automatic st_t ps_model(input st_t s);
      logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
      st_t r;
      x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
      x0 ^= x4; x4 ^= x3; x2 ^= x1;
      t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
      x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
      x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
      r[0] = x0; r[1] = x1; r[2] = x2; r[3] = x3; r[4] = x4;
      return r;
   endfunction

   function automatic st_t ps_inv_model(input st_t s);
      st_t r;
      logic [4:0] c, o;
      for (int j = 0; j < 64; j++) begin
         c = {s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]};
         o = inv_tab[c];
         r[0][j] = o[4]; r[1][j] = o[3]; r[2][j] = o[2]; r[3][j] = o[1]; r[4][j] = o[0];
      end
      return r;
   endfunction

   task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_state(input string name, input st_t exp);
      checks++;
      if (out_p !== exp || valid_out !== 1'b1) begin
         errors++;
         $display("FAIL %s: got %h/%h/%h/%h/%h v=%b expected %h/%h/%h/%h/%h v=1", name,
                  out_p[0], out_p[1], out_p[2], out_p[3], out_p[4], valid_out,
                  exp[0], exp[1], exp[2], exp[3], exp[4]);
      end
   endtask

   // Expected outputs: one-cycle delayed p_S, held while idle, cleared by reset
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_out   <= '0;
         exp_valid <= 1'b0;
      end else begin
`ifdef ASCON_PS_INV_EN
         if (valid_in) exp_out <= inv ? ps_inv_model(drv) : ps_model(drv);
`else
         if (valid_in) exp_out <= ps_model(drv);
`endif
         exp_valid <= valid_in;
      end
   end

   // Compare DUT against model every cycle, away from the active edge
   always @(negedge clk) begin
      if (cmp_en) begin
         check64("valid_o", {63'h0, valid_out}, {63'h0, exp_valid});
         for (int w = 0; w < 5; w++) begin
            check64($sformatf("stream_x%0d", w), out_p[w], exp_out[w]);
         end
      end
   end

   task automatic apply(input st_t s, input logic v);
      @(posedge clk);
      #1;
      drv      = s;
      valid_in = v;
   endtask

   initial begin
      st_t s, e, orig;
      logic [4:0] iv, f;

      // Pin the bitsliced model to the published table, derive inverse table
      for (int i = 0; i < 32; i++) begin
         iv = i[4:0];
         s = '0;
         for (int w = 0; w < 5; w++) s[w][0] = iv[4 - w];
         e = ps_model(s);
         f = {e[0][0], e[1][0], e[2][0], e[3][0], e[4][0]};
         check64($sformatf("model_s%0d", i), {59'h0, f}, {59'h0, spec_s[i]});
         inv_tab[f] = iv;
      end

      rst = 1'b1;
      #1;
      check64("reset_valid", {63'h0, valid_out}, 64'h0);
      for (int w = 0; w < 5; w++) check64($sformatf("reset_x%0d", w), out_p[w], 64'h0);
      @(posedge clk);
      #1;
      rst    = 1'b0;
      cmp_en = 1'b1;

      // All zeros
      apply('0, 1'b1);
      apply('0, 1'b0);
      #1;
      e = '0; e[2] = 64'hFFFFFFFFFFFFFFFF;
      check_state("all_zero", e);

      // All ones
      apply('1, 1'b1);
      apply('0, 1'b0);
      #1;
      e = '1; e[1] = 64'h0;
      check_state("all_ones", e);

      // x4 = 1
      s = '0; s[4] = 64'h1;
      apply(s, 1'b1);
      apply('0, 1'b0);
      #1;
      e[0] = 64'h0; e[1] = 64'h1; e[2] = 64'hFFFFFFFFFFFFFFFE; e[3] = 64'h1; e[4] = 64'h1;
      check_state("x4_one", e);

      // Mixed vector, column 0 has index 0x14 which maps to 0
      s[0] = 64'h00001000808C0001; s[1] = 64'h6CB10AD9CA912F80; s[2] = 64'h691AED630E8190EF;
      s[3] = 64'h0C4C36A20853217C; s[4] = 64'h46487B3E06D9D7A8;
      apply(s, 1'b1);
      apply('0, 1'b0);
      #1;
      for (int w = 0; w < 5; w++) check64($sformatf("vec5_bit0_x%0d", w), {63'h0, out_p[w][0]}, 64'h0);

      // Random stream, valid toggling
      for (int i = 0; i < 32; i++) begin
         for (int w = 0; w < 5; w++) s[w] = {$urandom(), $urandom()};
`ifdef ASCON_PS_INV_EN
         inv = 1'($urandom_range(0, 1));
`endif
         apply(s, 1'($urandom_range(0, 1)));
      end

      // Back-to-back stream, then reset mid-stream
      for (int i = 0; i < 6; i++) begin
         for (int w = 0; w < 5; w++) s[w] = {$urandom(), $urandom()};
         apply(s, 1'b1);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check64("midreset_valid", {63'h0, valid_out}, 64'h0);
      for (int w = 0; w < 5; w++) check64($sformatf("midreset_x%0d", w), out_p[w], 64'h0);
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      rst      = 1'b0;
      @(posedge clk);
      #1;
      check64("post_reset_valid", {63'h0, valid_out}, 64'h0);

`ifdef ASCON_PS_INV_EN
      // Forward then inverse must give back the original state
      for (int i = 0; i < 8; i++) begin
         for (int w = 0; w < 5; w++) orig[w] = {$urandom(), $urandom()};
         inv = 1'b0;
         apply(orig, 1'b1);
         apply('0, 1'b0);
         #1;
         s = out_p;
         inv = 1'b1;
         apply(s, 1'b1);
         apply('0, 1'b0);
         #1;
         check_state($sformatf("roundtrip%0d", i), orig);
      end
      inv = 1'b0;
`else
      orig = '0;
`endif

      apply('0, 1'b0);
      @(negedge clk);
      cmp_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
